// File: rtl/data_memory_unit_pkg.sv
// Shared processor package: bus width, DMU state encoding and the parity helper.
// DMU_PARITY_EN (optional) makes the memory store and check an even-parity bit per word.
package proc_pkg;

   localparam int BUS_W     = 24;
   localparam int DMU_CNT_W = 4;

   typedef enum logic [1:0] {
      DMU_IDLE    = 2'd0,
      DMU_RD_WAIT = 2'd1,
      DMU_WR_WAIT = 2'd2
   } dmu_state_t;

   // Returns the bit that makes the total count of ones (data + bit) even.
   function automatic logic even_parity(input logic [BUS_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the control path and the data memory unit.
// DMU_PARITY_EN adds the sticky parity_err response signal.
interface data_memory_unit_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 8
);
   import proc_pkg::*;

   // Handshake: mem_read/mem_write are sampled only while busy=0; requests seen
   // while busy=1 are dropped. The requester holds its request until done=1,
   // and may present the next request in the done cycle itself.
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] data_in;
   logic              mem_read;
   logic              mem_write;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] BUS_OUT;
   logic              collision;
`ifdef DMU_PARITY_EN
   logic              parity_err;
`endif
   dmu_state_t        dbg_state;

`ifdef DMU_PARITY_EN
   modport master (
      output addr_in, data_in, mem_read, mem_write,
      input  busy, done, BUS_OUT, collision, parity_err, dbg_state
   );
   modport slave (
      input  addr_in, data_in, mem_read, mem_write,
      output busy, done, BUS_OUT, collision, parity_err, dbg_state
   );
`else
   modport master (
      output addr_in, data_in, mem_read, mem_write,
      input  busy, done, BUS_OUT, collision, dbg_state
   );
   modport slave (
      input  addr_in, data_in, mem_read, mem_write,
      output busy, done, BUS_OUT, collision, dbg_state
   );
`endif

endinterface

// File: rtl/data_memory_unit_ram.sv
// Single-port word array: registered write, combinational read, no reset.
// Width is chosen by the parent (DATA_W, or DATA_W+1 when DMU_PARITY_EN is set).
module dmu_ram #(
   parameter int WIDTH  = 24,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_unit.sv
// Data memory unit: fixed-latency read/write engine in front of dmu_ram.
// DMU_PARITY_EN stores a parity bit per word and raises sticky parity_err on a bad read.
module data_memory_unit
   import proc_pkg::*;
#(
   parameter int DATA_W  = 24,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               reset,
   data_memory_unit_if.slave  bus
);

`ifdef DMU_PARITY_EN
   localparam int RAM_W = DATA_W + 1;
`else
   localparam int RAM_W = DATA_W;
`endif
   localparam logic [DMU_CNT_W-1:0] CNT_LOAD = DMU_CNT_W'(LATENCY - 1);

   dmu_state_t           state_q, state_d;
   logic [DMU_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [DATA_W-1:0]    bus_out_q, bus_out_d;
   logic                 done_q, done_d;
   logic                 collision_q, collision_d;
   logic                 ram_we;
   logic [RAM_W-1:0]     ram_wdata;
   logic [RAM_W-1:0]     ram_rdata;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      bus_out_d   = bus_out_q;
      done_d      = 1'b0;
      collision_d = collision_q;
      ram_we      = 1'b0;
      case (state_q)
         DMU_IDLE: begin
            // A simultaneous read is discarded in favour of the write.
            if (bus.mem_write) begin
               addr_d  = bus.addr_in;
               wdata_d = bus.data_in;
               cnt_d   = CNT_LOAD;
               state_d = DMU_WR_WAIT;
               if (bus.mem_read) begin
                  collision_d = 1'b1;
               end
            end else if (bus.mem_read) begin
               addr_d  = bus.addr_in;
               cnt_d   = CNT_LOAD;
               state_d = DMU_RD_WAIT;
            end
         end
         DMU_RD_WAIT: begin
            if (cnt_q == '0) begin
               bus_out_d = ram_rdata[DATA_W-1:0];
               done_d    = 1'b1;
               state_d   = DMU_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DMU_WR_WAIT: begin
            if (cnt_q == '0) begin
               ram_we  = 1'b1;
               done_d  = 1'b1;
               state_d = DMU_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = DMU_IDLE;
         end
      endcase
   end

   // The array commits only on the completing edge, so a reset mid-write leaves it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= DMU_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         bus_out_q   <= '0;
         done_q      <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         bus_out_q   <= bus_out_d;
         done_q      <= done_d;
         collision_q <= collision_d;
      end
   end

`ifdef DMU_PARITY_EN
   logic parity_err_q, parity_err_d;

   assign ram_wdata = {even_parity(wdata_q), wdata_q};

   always_comb begin
      parity_err_d = parity_err_q;
      if (state_q == DMU_RD_WAIT && cnt_q == '0 &&
          even_parity(ram_rdata[DATA_W-1:0]) != ram_rdata[DATA_W]) begin
         parity_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign bus.parity_err = parity_err_q;
`else
   assign ram_wdata = wdata_q;
`endif

   dmu_ram #(
      .WIDTH  (RAM_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (addr_q),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   assign bus.busy      = (state_q != DMU_IDLE);
   assign bus.done      = done_q;
   assign bus.BUS_OUT   = bus_out_q;
   assign bus.collision = collision_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: directed cases, then a random run of transfers.
// The DMU_PARITY_EN section corrupts a stored word and expects parity_err.
module tb_data_memory_unit;
   import proc_pkg::*;

   localparam int DATA_W  = 24;
   localparam int ADDR_W  = 8;
   localparam int LATENCY = 2;

   logic clk;
   logic reset;

   data_memory_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   data_memory_unit #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] model [2**ADDR_W];
   bit                written [2**ADDR_W];
   logic [DATA_W-1:0] last_rd;
   int                n_cmp;
   int                n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge with the DUT idle (or in its done cycle).
   task automatic run_req(input logic wr, input logic rd,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int j;
      logic [DATA_W-1:0] exp_rd;
      bus.mem_write = wr;
      bus.mem_read  = rd;
      bus.addr_in   = a;
      bus.data_in   = d;
      if (!wr && rd) exp_q.push_back(model[a]);
      @(posedge clk); #1;
      j = 0;
      while (bus.done !== 1'b1 && j < 20) begin
         check("busy_during", {31'd0, bus.busy}, 32'd1);
         @(posedge clk); #1;
         j++;
      end
      check("done_latency", 32'(j), 32'(LATENCY));
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b0;
      if (wr) begin
         model[a]   = d;
         written[a] = 1'b1;
         check("bus_hold_wr", 32'(bus.BUS_OUT), 32'(last_rd));
      end else if (rd) begin
         if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
         end else begin
            exp_rd = exp_q.pop_front();
            check("rd_data", 32'(bus.BUS_OUT), 32'(exp_rd));
            last_rd = exp_rd;
         end
      end
   endtask

   task automatic idle(input int n);
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("idle_done", {31'd0, bus.done}, 32'd0);
         check("idle_busy", {31'd0, bus.busy}, 32'd0);
         check("idle_hold", 32'(bus.BUS_OUT), 32'(last_rd));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
      check({tag, "_done"},  {31'd0, bus.done}, 32'd0);
      check({tag, "_bus"},   32'(bus.BUS_OUT), 32'd0);
      check({tag, "_coll"},  {31'd0, bus.collision}, 32'd0);
      check({tag, "_state"}, 32'(bus.dbg_state), 32'(DMU_IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_data;
      n_cmp = 0;
      n_err = 0;
      last_rd = '0;
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b0;
      bus.addr_in   = '0;
      bus.data_in   = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Write then read address 0x05.
      run_req(1'b1, 1'b0, 8'h05, 24'd100);
      idle(2);
      run_req(1'b0, 1'b1, 8'h05, '0);
      idle(5);

      // Back-to-back write/read of the all-ones word.
      run_req(1'b1, 1'b0, 8'hFF, 24'hFFFFFF);
      run_req(1'b0, 1'b1, 8'hFF, '0);
      idle(2);

      // Collision: write wins, flag is sticky.
      check("coll_before", {31'd0, bus.collision}, 32'd0);
      run_req(1'b1, 1'b1, 8'h10, 24'd7);
      check("coll_set", {31'd0, bus.collision}, 32'd1);
      idle(2);
      run_req(1'b0, 1'b1, 8'h10, '0);
      idle(1);
      check("coll_sticky", {31'd0, bus.collision}, 32'd1);

      // Reset one cycle into a write: write is aborted.
      bus.mem_write = 1'b1;
      bus.addr_in   = 8'h05;
      bus.data_in   = 24'd55;
      @(posedge clk); #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      bus.mem_write = 1'b0;
      #1;
      check_reset_vals("abort");
      last_rd = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      run_req(1'b0, 1'b1, 8'h05, '0);
      idle(1);

      // Random transfers with random gaps (0 = back-to-back).
      for (int n = 0; n < 40; n++) begin
         ra = ADDR_W'($urandom_range(0, 15));
         if (written[ra] && $urandom_range(0, 1) == 1) begin
            run_req(1'b0, 1'b1, ra, '0);
         end else begin
            rd_data = DATA_W'($urandom_range(0, 32'hFFFFFF));
            run_req(1'b1, 1'b0, ra, rd_data);
         end
         idle($urandom_range(0, 2));
      end

`ifdef DMU_PARITY_EN
      check("parity_clean", {31'd0, bus.parity_err}, 32'd0);
      run_req(1'b1, 1'b0, 8'h05, 24'd100);
      idle(1);
      dut.u_ram.mem_q[5][0] = ~dut.u_ram.mem_q[5][0];
      model[5] = model[5] ^ 24'd1;
      run_req(1'b0, 1'b1, 8'h05, '0);
      check("parity_err", {31'd0, bus.parity_err}, 32'd1);
      idle(2);
      check("parity_sticky", {31'd0, bus.parity_err}, 32'd1);
`endif

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Word-addressed data memory that sits on the far side of the processor's 24-bit shared bus and services read/write transfers started by the accumulator and address register. A write stores the bus word at the latched address; a read returns the stored word on `BUS_OUT` after a fixed, parameterised access latency. Completion is signalled with a one-cycle `done` pulse that the control unit waits on before advancing the microinstruction.

## Interface
- `DATA_W`, 24, bus and memory word width
- `ADDR_W`, 8, address width; depth is 2**ADDR_W words
- `LATENCY`, 2, access latency in cycles; legal range 1..15

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `addr_in`  in  ADDR_W  word address from the address register
- `data_in`  in  DATA_W  write data from the bus (accumulator output)
- `mem_read`  in  1  read request, sampled only in IDLE
- `mem_write`  in  1  write request, sampled only in IDLE
- `busy`  out  1  access in progress; requests ignored
- `done`  out  1  one-cycle completion pulse
- `BUS_OUT`  out  DATA_W  read data toward the bus/accumulator
- `collision`  out  1  sticky flag: read and write requested in the same accepting cycle

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE, `mem_write`=1 on an edge: latch `addr_in` and `data_in`, load counter with LATENCY-1, go to WR_WAIT.
- IDLE, `mem_read`=1, `mem_write`=0: latch `addr_in`, load counter, go to RD_WAIT.
- Both high in IDLE: the write is taken, `collision` set to 1 and held until reset.
- RD_WAIT/WR_WAIT: decrement counter each edge. On the edge where the counter equals 0:
  - RD_WAIT: `BUS_OUT` loads the word at the latched address.
  - WR_WAIT: the array is written with the latched data.
  - Both states: `done` goes to 1 and the FSM returns to IDLE.
- `done` is high for exactly one cycle. `busy` is 1 in RD_WAIT/WR_WAIT and 0 otherwise.
- `BUS_OUT` holds the last read value until the next read completes. It does not change on writes.
- A read of an address written earlier returns the written word. A read of a never-written address returns an undefined value; benches must not check it.
- Requests presented while `busy`=1 are dropped, not queued. The requester holds a request until it sees `done`.

## Timing
- Request sampled at edge k: `busy`=1 from edge k+1; `done`=1 and `BUS_OUT` valid from edge k+LATENCY for one cycle; `busy`=0 from edge k+LATENCY.
- Back-to-back: a new request may be sampled at edge k+LATENCY+1, while `done` is still high. Minimum period is LATENCY+1 cycles.
- Reset values: `busy`=0, `done`=0, `BUS_OUT`=0, `collision`=0, FSM=IDLE, counter=0.
- Reset mid-access aborts the access. A pending write is not committed. Array contents are not cleared by reset.
- LATENCY=1: the counter loads 0 and the access completes on the first edge after acceptance.

## Configuration
- `DMU_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed from `data_in` at write time.
  - On read completion the parity is rechecked, and a mismatch sets output `parity_err`.
  - `parity_err` is sticky and cleared only by reset.
- Not defined: no parity storage and no `parity_err` port; the array is DATA_W bits wide.

## Structure
- Shared package `proc_pkg`:
  - FSM state enum `dmu_state_t`
  - bus width constant `BUS_W`=24
  - helper function `even_parity`
- Sub-module `dmu_ram`: single-port synchronous array with registered write, combinational read, and width DATA_W (+1 with parity). The FSM and counter stay in the top module.

## Test plan
- Reset release, then write 24'd100 to address 8'h05 with LATENCY=2 -> `busy` high 2 cycles, `done` pulses at edge k+2, `BUS_OUT` stays 0.
- Read address 8'h05 -> `BUS_OUT`=24'd100 exactly at edge k+2 alongside `done`; value held for the following 5 idle cycles.
- Write 24'hFFFFFF to 8'hFF, then read 8'hFF back-to-back with no idle gap -> `BUS_OUT`=24'hFFFFFF; read accepted on the `done` cycle.
- `mem_read` and `mem_write` high together, writing 24'd7 to 8'h10 -> write performed, `collision`=1 and sticky; a later read of 8'h10 returns 24'd7.
- Assert `reset` one cycle into a write of 24'd55 to 8'h05 (holding 24'd100) -> outputs return to reset values; a later read of 8'h05 returns 24'd100.
- With `DMU_PARITY_EN`, force one stored data bit flipped via hierarchical write, then read that address -> `parity_err`=1 at `done`.
